cop0_irq_ctrl: RTL and testbench

//  Coprocessor-0 exception and interrupt controller for the 5-stage MIPS pipeline.

---
 rtl/cop0_irq_ctrl.sv | 146 ++++++++++++++
 tb/tb_cop0_irq_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/cop0_irq_ctrl.sv
// Coprocessor-0 exception/interrupt controller: STATUS/CAUSE/EPC, prioritised
// exception entry, eret, and the pipeline flush/kill/redirect controls.
module cop0_irq_ctrl #(
    parameter int unsigned N_IRQ        = 8,
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_0080
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [N_IRQ-1:0] i_irq,
    input  logic             i_arithmetic_overflow,
    input  logic             i_unknown_command,
    input  logic             i_unknown_func,
    input  logic [31:0]      i_pc_ex,
    input  logic [31:0]      i_pc_id,
    input  logic             i_mtc0,
    input  logic             i_eret,
    input  logic [4:0]       i_address,
    input  logic [31:0]      i_data,
    output logic [31:0]      o_data,
    output logic             o_exception,
    output logic             o_kill_ex,
    output logic             o_redirect,
    output logic [31:0]      o_redirect_pc
);

    typedef enum logic [1:0] {RUN, TAKE, RET} state_t;

    state_t             r_state, w_next;
    logic               r_ie, r_exl;
    logic [N_IRQ-1:0]   r_im, r_ip;
    logic [4:0]         r_exccode;
    logic [31:0]        r_epc;

    logic               w_int_req, w_take, w_ret, w_wr;
    logic [4:0]         w_code;
    logic [31:0]        w_epc_new;

    assign w_int_req = r_ie & ~r_exl & (|(r_ip & r_im));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= RUN;
        else          r_state <= w_next;
    end

    // Priority chain: an accepted exception squashes any eret/mtc0 in the same cycle.
    always_comb begin
        w_next        = r_state;
        o_exception   = 1'b0;
        o_kill_ex     = 1'b0;
        o_redirect    = 1'b0;
        o_redirect_pc = '0;
        w_take        = 1'b0;
        w_ret         = 1'b0;
        w_wr          = 1'b0;
        w_code        = '0;
        w_epc_new     = r_epc;
        case (r_state)
            RUN: begin
                if (i_arithmetic_overflow) begin
                    o_exception = 1'b1;
                    o_kill_ex   = 1'b1;
                    w_take      = 1'b1;
                    w_code      = 5'd12;
                    w_epc_new   = i_pc_ex;
                    w_next      = TAKE;
                end else if ((i_unknown_command | i_unknown_func) & ~r_exl) begin
                    o_exception = 1'b1;
                    w_take      = 1'b1;
                    w_code      = 5'd10;
                    w_epc_new   = i_pc_id;
                    w_next      = TAKE;
                end else if (w_int_req) begin
                    o_exception = 1'b1;
                    w_take      = 1'b1;
                    w_code      = 5'd0;
                    w_epc_new   = i_pc_id;
                    w_next      = TAKE;
                end else if (i_eret) begin
                    w_ret  = 1'b1;
                    w_next = RET;
                end else if (i_mtc0) begin
                    w_wr = 1'b1;
                end
            end
            TAKE: begin
                o_redirect    = 1'b1;
                o_redirect_pc = HANDLER_ADDR;
                w_next        = RUN;
            end
            RET: begin
                o_redirect    = 1'b1;
                o_redirect_pc = r_epc;
                w_next        = RUN;
            end
            default: w_next = RUN;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ie      <= 1'b0;
            r_exl     <= 1'b0;
            r_im      <= '0;
            r_ip      <= '0;
            r_exccode <= '0;
            r_epc     <= '0;
        end else begin
            r_ip <= i_irq;
            if (w_take) begin
                r_exl     <= 1'b1;
                r_exccode <= w_code;
                r_epc     <= w_epc_new;
            end else if (w_ret) begin
                r_exl <= 1'b0;
            end else if (w_wr) begin
                case (i_address)
                    5'd12: begin
                        r_ie  <= i_data[0];
                        r_exl <= i_data[1];
                        r_im  <= i_data[8 +: N_IRQ];
                    end
                    5'd14:   r_epc <= i_data;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        o_data = '0;
        case (i_address)
            5'd12: begin
                o_data[0]          = r_ie;
                o_data[1]          = r_exl;
                o_data[8 +: N_IRQ] = r_im;
            end
            5'd13: begin
                o_data[6:2]        = r_exccode;
                o_data[8 +: N_IRQ] = r_ip;
            end
            5'd14:   o_data = r_epc;
            default: o_data = '0;
        endcase
    end

endmodule

// File: tb/tb_cop0_irq_ctrl.sv
// Scoreboard bench for cop0_irq_ctrl: directed scenarios followed by random
// traffic, checked against a behavioural model with a redirect queue.
module tb_cop0_irq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  irq = '0;
    logic        ovf = 1'b0, uc = 1'b0, uf = 1'b0, mtc0 = 1'b0, eret = 1'b0;
    logic [31:0] pc_ex = '0, pc_id = '0, wdata = '0;
    logic [4:0]  addr = '0;
    logic [31:0] o_data, o_redirect_pc;
    logic        o_exception, o_kill_ex, o_redirect;

    always #5 clk = ~clk;

    cop0_irq_ctrl #(.N_IRQ(8), .HANDLER_ADDR(32'h0000_0080)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_irq(irq),
        .i_arithmetic_overflow(ovf), .i_unknown_command(uc), .i_unknown_func(uf),
        .i_pc_ex(pc_ex), .i_pc_id(pc_id), .i_mtc0(mtc0), .i_eret(eret),
        .i_address(addr), .i_data(wdata), .o_data(o_data),
        .o_exception(o_exception), .o_kill_ex(o_kill_ex),
        .o_redirect(o_redirect), .o_redirect_pc(o_redirect_pc)
    );

    typedef struct packed {
        logic        exc;
        logic        kill;
        logic        redir;
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference state: architectural registers plus a queue of pending PC loads.
    bit          m_ie, m_exl;
    logic [7:0]  m_im, m_ip;
    logic [4:0]  m_code;
    logic [31:0] m_epc;
    logic [31:0] m_redir[$];

    task automatic model_reset();
        m_ie = 0; m_exl = 0; m_im = '0; m_ip = '0; m_code = '0; m_epc = '0;
        m_redir.delete();
    endtask

    task automatic model_cycle();
        exp_t e;
        e = '0;
        if (!rst_n) begin
            model_reset();
            exp_q.push_back(e);
            return;
        end
        if (addr == 5'd12)      e.data = {16'b0, m_im, 6'b0, m_exl, m_ie};
        else if (addr == 5'd13) e.data = {16'b0, m_ip, 1'b0, m_code, 2'b0};
        else if (addr == 5'd14) e.data = m_epc;
        if (m_redir.size() != 0) begin
            e.redir = 1;
            e.pc    = m_redir.pop_front();
        end else if (ovf) begin
            e.exc = 1; e.kill = 1;
            m_epc = pc_ex; m_code = 12; m_exl = 1; m_redir.push_back(32'h80);
        end else if ((uc || uf) && !m_exl) begin
            e.exc = 1;
            m_epc = pc_id; m_code = 10; m_exl = 1; m_redir.push_back(32'h80);
        end else if (m_ie && !m_exl && ((m_ip & m_im) != 0)) begin
            e.exc = 1;
            m_epc = pc_id; m_code = 0; m_exl = 1; m_redir.push_back(32'h80);
        end else if (eret) begin
            m_exl = 0; m_redir.push_back(m_epc);
        end else if (mtc0) begin
            if (addr == 5'd12) begin
                m_ie = wdata[0]; m_exl = wdata[1]; m_im = wdata[15:8];
            end else if (addr == 5'd14) begin
                m_epc = wdata;
            end
        end
        m_ip = irq;
        exp_q.push_back(e);
    endtask

    task automatic step(input logic r, input logic [7:0] q, input logic o, input logic c,
                        input logic f, input logic w, input logic t, input logic [4:0] a,
                        input logic [31:0] d, input logic [31:0] px, input logic [31:0] pi);
        @(posedge clk);
        #1;
        rst_n = r; irq = q; ovf = o; uc = c; uf = f; mtc0 = w; eret = t;
        addr = a; wdata = d; pc_ex = px; pc_id = pi;
        model_cycle();
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("o_exception",   {31'b0, o_exception}, {31'b0, e.exc});
                check("o_kill_ex",     {31'b0, o_kill_ex},   {31'b0, e.kill});
                check("o_redirect",    {31'b0, o_redirect},  {31'b0, e.redir});
                check("o_redirect_pc", o_redirect_pc,        e.pc);
                check("o_data",        o_data,               e.data);
            end
        end
    end

    initial begin
        logic [4:0] a;
        logic       r;
        model_reset();
        // Reset state, then interrupt entry through IM[1]
        step(0, 0, 0, 0, 0, 0, 0, 5'd0,  0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 5'd12, 0, 0, 0);
        step(1, 0, 0, 0, 0, 1, 0, 5'd12, 32'h301, 0, 0);
        step(1, 8'h02, 0, 0, 0, 0, 0, 5'd13, 0, 32'h10, 32'h1234);
        step(1, 8'h02, 0, 0, 0, 0, 0, 5'd13, 0, 32'h10, 32'h1234);
        step(1, 0, 0, 0, 0, 0, 0, 5'd13, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 5'd14, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 1, 5'd12, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 5'd12, 0, 0, 0);
        // Reserved instruction, then eret back to it
        step(1, 0, 0, 0, 1, 0, 0, 5'd13, 0, 32'h44, 32'h40);
        step(1, 0, 0, 0, 0, 0, 0, 5'd14, 0, 0, 0);
        step(1, 0, 0, 0, 1, 0, 0, 5'd12, 0, 0, 32'h50);
        step(1, 0, 0, 0, 0, 0, 1, 5'd14, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 5'd12, 0, 0, 0);
        // Overflow beats reserved instruction
        step(1, 0, 1, 1, 0, 0, 0, 5'd13, 0, 32'h200, 32'h204);
        step(1, 0, 0, 0, 0, 0, 0, 5'd13, 0, 0, 0);
        step(1, 0, 1, 0, 0, 0, 0, 5'd14, 0, 32'h300, 0);
        step(1, 0, 0, 0, 0, 0, 0, 5'd14, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 1, 5'd13, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 5'd12, 0, 0, 0);
        // Masking by IM, IE and EXL; unmasking takes effect one cycle later
        step(1, 8'hFF, 0, 0, 0, 1, 0, 5'd12, 32'h0001, 0, 0);
        step(1, 8'hFF, 0, 0, 0, 0, 0, 5'd13, 0, 0, 32'h600);
        step(1, 8'hFF, 0, 0, 0, 1, 0, 5'd12, 32'hFF00, 0, 32'h604);
        step(1, 8'hFF, 0, 0, 0, 0, 0, 5'd12, 0, 0, 32'h608);
        step(1, 8'hFF, 0, 0, 0, 1, 0, 5'd12, 32'hFF03, 0, 32'h60C);
        step(1, 8'hFF, 0, 0, 0, 0, 0, 5'd12, 0, 0, 32'h610);
        step(1, 8'hFF, 0, 0, 0, 1, 0, 5'd12, 32'hFF01, 0, 32'h614);
        step(1, 8'hFF, 0, 0, 0, 0, 0, 5'd13, 0, 0, 32'h618);
        step(1, 0, 0, 0, 0, 0, 0, 5'd14, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 1, 5'd12, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 5'd12, 0, 0, 0);
        // mtc0 EPC racing eret: eret wins
        step(1, 0, 0, 0, 0, 1, 1, 5'd14, 32'h100, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 5'd14, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 5'd14, 0, 0, 0);
        // Reset while the handler redirect is in flight
        step(1, 0, 0, 1, 0, 0, 0, 5'd14, 0, 0, 32'h900);
        step(0, 0, 0, 0, 0, 0, 0, 5'd14, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 5'd12, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 5'd13, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 5'd13, 0, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 4))
                0:       a = 5'd12;
                1:       a = 5'd13;
                2:       a = 5'd14;
                default: a = 5'($urandom);
            endcase
            r = ($urandom_range(0, 299) != 0);
            step(r,
                 ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00,
                 r && ($urandom_range(0, 29) == 0),
                 r && ($urandom_range(0, 29) == 0),
                 r && ($urandom_range(0, 29) == 0),
                 ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 7) == 0),
                 a, $urandom, $urandom, $urandom);
        end

        repeat (3) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
